dm_access_ctrl: RTL and testbench

Multi-cycle data-memory access sequencer between the CPU's MEM stage and a word-only data memory that has a request/acknowledge handshake and no byte enables. It accepts one load or store at a time and stalls the CPU via `cpu_busy`. Sub-word stores (SH/SB) are performed as read-modify-write. Sub-word loads are extracted and sign- or zero-extended. Misaligned accesses and memory timeouts are reported as errors, and a misaligned access never touches memory.

---
 rtl/mem_defs.sv | 18 +
 rtl/dm_lane_unit.sv | 31 +++
 rtl/dm_access_ctrl.sv | 105 ++++++++++
 tb/tb_dm_access_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// mem_defs: shared size, state and error-cause encodings for the data-memory path
package mem_defs;
    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD = 2'd1;
    localparam logic [1:0] ST_WR = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_ALIGN = 2'd1;
    localparam logic [1:0] ERR_SIZE = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_RSV || (size == SZ_W && off != 2'b00) || (size == SZ_H && off[0]);
    endfunction
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: little-endian sub-word merge (for stores) and extract (for loads)
// word: memory word; wdata: right-justified store data; size/offset/sign: access shape
// merged: word with the target lane replaced; extracted: sign/zero-extended lane
module dm_lane_unit
    import mem_defs::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign,
    output logic [31:0] merged,
    output logic [31:0] extracted
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{offset, 3'b000} +: 8];
    assign h = offset[1] ? word[31:16] : word[15:0];
    assign extracted = size == SZ_B ? {{24{sign & b[7]}}, b}
                     : size == SZ_H ? {{16{sign & h[15]}}, h} : word;
    always_comb begin
        merged = wdata;
        if (size == SZ_B) begin
            merged = word;
            merged[{offset, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_H) begin
            merged = word;
            merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        end
    end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: one-at-a-time load/store sequencer to a word-only req/ack data memory
// cpu_*: request (req/we/size/sign/addr/wdata) and response (busy/done/err/rdata)
// mem_*: registered word request (req/we/addr/wdata) and response (rdata/ack)
// reset is synchronous active-low; TIMEOUT bounds the ack wait per RD/WR state
module dm_access_ctrl
    import mem_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    logic [1:0]  state, size, off, cause;
    logic        we, sign, bad, tmo;
    logic [31:0] wdata, merged, extracted;
    logic [7:0]  cnt;
    assign bad = bad_access(cpu_size, cpu_addr[1:0]);
    // abort on the edge where the wait counter would reach TIMEOUT
    assign tmo = !mem_ack && (cnt + 8'd1) == 8'(TIMEOUT);
    assign cpu_busy = state != ST_IDLE;
    assign cpu_done = state == ST_RESP;
    assign cpu_err = cpu_done && cause != ERR_NONE;
    dm_lane_unit u_lane (
        .word(mem_rdata),
        .wdata(wdata),
        .size(size),
        .offset(off),
        .sign(sign),
        .merged(merged),
        .extracted(extracted)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            size <= SZ_W;
            off <= 2'b00;
            cause <= ERR_NONE;
            we <= 1'b0;
            sign <= 1'b0;
            wdata <= '0;
            cnt <= '0;
            cpu_rdata <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cpu_req) begin
                    we <= cpu_we;
                    size <= cpu_size;
                    sign <= cpu_sign;
                    off <= cpu_addr[1:0];
                    wdata <= cpu_wdata;
                    cnt <= '0;
                    mem_addr <= {cpu_addr[31:2], 2'b00};
                    cause <= cpu_size == SZ_RSV ? ERR_SIZE : bad ? ERR_ALIGN : ERR_NONE;
                    if (bad) state <= ST_RESP;
                    else begin
                        mem_req <= 1'b1;
                        mem_we <= cpu_we && cpu_size == SZ_W;
                        mem_wdata <= cpu_wdata;
                        state <= cpu_we && cpu_size == SZ_W ? ST_WR : ST_RD;
                    end
                end
                ST_RD, ST_WR: if (mem_ack) begin
                    cnt <= '0;
                    // sub-word store: keep mem_req high and turn the read into the write
                    if (state == ST_RD && we) begin
                        mem_we <= 1'b1;
                        mem_wdata <= merged;
                        state <= ST_WR;
                    end else begin
                        if (state == ST_RD) cpu_rdata <= extracted;
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        state <= ST_RESP;
                    end
                end else if (tmo) begin
                    mem_req <= 1'b0;
                    mem_we <= 1'b0;
                    cause <= ERR_TIMEOUT;
                    state <= ST_RESP;
                end else cnt <= cnt + 8'd1;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed self-checking bench for dm_access_ctrl
module tb_dm_access_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
    logic [1:0]  cpu_size = 2'b00;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_busy, cpu_done, cpu_err, mem_req, mem_we, mem_ack;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        ack_en = 1'b1, ack_wr = 1'b1;
    logic [31:0] mem_word = '0;
    int          vectors = 0, miscompares = 0;
    int          cyc, n;
    logic        err;
    logic [31:0] rd;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sign(cpu_sign),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    // zero-wait memory model: acks in the first cycle of mem_req when enabled
    assign mem_ack = ack_en && mem_req && (!mem_we || ack_wr);
    assign mem_rdata = mem_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_sign = sign;
        cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic wait_done(output int c, output logic e, output logic [31:0] r);
        c = 0; e = 1'b0; r = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                c = i; e = cpu_err; r = cpu_rdata;
                return;
            end
        end
    endtask

    task automatic load(input string tag, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, sign, addr, 32'h0);
        wait_done(cyc, err, rd);
        chk({tag, "_cyc"}, cyc, 2);
        chk({tag, "_data"}, rd, exp);
    endtask

    task automatic bad(input string tag, input logic we, input logic [1:0] size, input logic [31:0] addr);
        issue(we, size, 1'b0, addr, 32'h5555_5555);
        @(negedge clk);
        chk({tag, "_done_err_req"}, {29'd0, cpu_done, cpu_err, mem_req}, 32'b110);
        chk({tag, "_rdata"}, cpu_rdata, 32'h0000_8000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {28'd0, cpu_busy, cpu_done, cpu_err, mem_req | mem_we}, 32'd0);
        chk("reset_data", cpu_rdata | mem_addr | mem_wdata, 32'd0);
        reset = 1'b1;

        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_req_we", {30'd0, mem_req, mem_we}, 32'b11);
        chk("sw_addr", mem_addr, 32'h10);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_done_err_req", {29'd0, cpu_done, cpu_err, mem_req}, 32'b100);

        mem_word = 32'h1122_3344;
        issue(1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_rd", {30'd0, mem_req, mem_we}, 32'b10);
        chk("sb_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("sb_wr", {30'd0, mem_req, mem_we}, 32'b11);
        chk("sb_wdata", mem_wdata, 32'hAB22_3344);
        @(negedge clk);
        chk("sb_done_err", {30'd0, cpu_done, cpu_err}, 32'b10);

        mem_word = 32'h8000_FF80;
        load("lw", 2'b00, 1'b0, 32'h20, 32'h8000_FF80);
        load("lb", 2'b10, 1'b1, 32'h20, 32'hFFFF_FF80);
        load("lbu", 2'b10, 1'b0, 32'h20, 32'h0000_0080);
        load("lb1", 2'b10, 1'b1, 32'h21, 32'hFFFF_FFFF);
        load("lbu3", 2'b10, 1'b0, 32'h23, 32'h0000_0080);
        load("lh", 2'b01, 1'b1, 32'h22, 32'hFFFF_8000);
        load("lh0", 2'b01, 1'b1, 32'h20, 32'hFFFF_FF80);
        load("lhu", 2'b01, 1'b0, 32'h22, 32'h0000_8000);

        bad("sh_mis", 1'b1, 2'b01, 32'h21);
        bad("lw_mis", 1'b0, 2'b00, 32'h22);
        bad("size11", 1'b0, 2'b11, 32'h20);

        ack_en = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (mem_req && !cpu_done) n++;
        end
        chk("tmo_req_cycles", n, 4);
        @(negedge clk);
        chk("tmo_done_err_req", {29'd0, cpu_done, cpu_err, mem_req}, 32'b110);
        chk("tmo_rdata", cpu_rdata, 32'h0000_8000);
        ack_en = 1'b1;

        ack_wr = 1'b0;
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        chk("rst_sh_wr", {30'd0, mem_req, mem_we}, 32'b11);
        chk("rst_sh_wdata", mem_wdata, 32'h1234_FF80);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_abort", {29'd0, mem_req, cpu_busy, cpu_done}, 32'd0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_done || mem_req) n++;
        end
        chk("rst_quiet", n, 0);
        ack_wr = 1'b1;
        mem_word = 32'hCAFE_0001;
        load("lw_after_rst", 2'b00, 1'b0, 32'h40, 32'hCAFE_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
